dram_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of the single-request DRAM controller port
//  (addr_dram/din_dram/rw_dram/valid_dram -> dout_dram/ready_dram). Serialises

---
 rtl/dram_arb_pkg.sv | 14 +
 rtl/rr_arbiter2.sv | 21 ++
 rtl/dram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// Shared widths, read/write encoding and sequencer state type for the DRAM arbiter.
package dram_arb_pkg;
    localparam int ADDR_W = 27;
    localparam int DATA_W = 32;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant selection: single requester wins; on a tie either round-robin
// against the last grant or fixed preference for port 0.
module rr_arbiter2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_port
);
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_port  = 1'b0;
        if (req0 && req1) begin
            gnt_port = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        end else if (req1) begin
            gnt_port = 1'b1;
        end
    end
endmodule

// File: rtl/dram_arbiter.sv
// Two-port sequencer in front of the single-request DRAM controller port; one
// transaction outstanding, registered outputs, sticky watchdog on slow completions.
module dram_arbiter #(
    parameter int ADDR_W         = dram_arb_pkg::ADDR_W,
    parameter int DATA_W         = dram_arb_pkg::DATA_W,
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              p0_valid,
    input  logic              p0_rw,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_din,
    output logic              p0_ready,
    output logic [DATA_W-1:0] p0_dout,
    input  logic              p1_valid,
    input  logic              p1_rw,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_din,
    output logic              p1_ready,
    output logic [DATA_W-1:0] p1_dout,
    output logic [ADDR_W-1:0] addr_dram,
    output logic [DATA_W-1:0] din_dram,
    output logic              rw_dram,
    output logic              valid_dram,
    input  logic [DATA_W-1:0] dout_dram,
    input  logic              ready_dram,
    output logic              busy,
    output logic              err_timeout
);
    import dram_arb_pkg::state_t;
    import dram_arb_pkg::IDLE;
    import dram_arb_pkg::ISSUE;
    import dram_arb_pkg::RESP;
    import dram_arb_pkg::RW_READ;

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_dram_q, addr_dram_d;
    logic [DATA_W-1:0] din_dram_q, din_dram_d;
    logic              rw_dram_q, rw_dram_d;
    logic              valid_dram_q, valid_dram_d;
    logic              p0_ready_q, p0_ready_d;
    logic              p1_ready_q, p1_ready_d;
    logic [DATA_W-1:0] p0_dout_q, p0_dout_d;
    logic [DATA_W-1:0] p1_dout_q, p1_dout_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_q, gnt_d;
    logic [CNT_W-1:0]  wd_q, wd_d;

    logic gnt_valid;
    logic gnt_port;

    rr_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .req0       (p0_valid),
        .req1       (p1_valid),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_port   (gnt_port)
    );

    always_comb begin
        state_d      = state_q;
        addr_dram_d  = addr_dram_q;
        din_dram_d   = din_dram_q;
        rw_dram_d    = rw_dram_q;
        valid_dram_d = valid_dram_q;
        p0_ready_d   = p0_ready_q;
        p1_ready_d   = p1_ready_q;
        p0_dout_d    = p0_dout_q;
        p1_dout_d    = p1_dout_q;
        busy_d       = busy_q;
        err_d        = err_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        wd_d         = wd_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    gnt_d        = gnt_port;
                    last_grant_d = gnt_port;
                    addr_dram_d  = gnt_port ? p1_addr : p0_addr;
                    din_dram_d   = gnt_port ? p1_din  : p0_din;
                    rw_dram_d    = gnt_port ? p1_rw   : p0_rw;
                    valid_dram_d = 1'b1;
                    busy_d       = 1'b1;
                    wd_d         = '0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (ready_dram) begin
                    valid_dram_d = 1'b0;
                    state_d      = RESP;
                    if (gnt_q) begin
                        p1_ready_d = 1'b1;
                        if (rw_dram_q == RW_READ) p1_dout_d = dout_dram;
                    end else begin
                        p0_ready_d = 1'b1;
                        if (rw_dram_q == RW_READ) p0_dout_d = dout_dram;
                    end
                end else if (WD_EN) begin
                    // Saturating count; the flag is sticky and never aborts the access.
                    if (wd_q != CNT_MAX) wd_d = wd_q + 1'b1;
                    if (wd_d == CNT_MAX) err_d = 1'b1;
                end
            end
            RESP: begin
                p0_ready_d = 1'b0;
                p1_ready_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_dram_q  <= '0;
            din_dram_q   <= '0;
            rw_dram_q    <= 1'b0;
            valid_dram_q <= 1'b0;
            p0_ready_q   <= 1'b0;
            p1_ready_q   <= 1'b0;
            p0_dout_q    <= '0;
            p1_dout_q    <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            addr_dram_q  <= addr_dram_d;
            din_dram_q   <= din_dram_d;
            rw_dram_q    <= rw_dram_d;
            valid_dram_q <= valid_dram_d;
            p0_ready_q   <= p0_ready_d;
            p1_ready_q   <= p1_ready_d;
            p0_dout_q    <= p0_dout_d;
            p1_dout_q    <= p1_dout_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            wd_q         <= wd_d;
        end
    end

    assign addr_dram   = addr_dram_q;
    assign din_dram    = din_dram_q;
    assign rw_dram     = rw_dram_q;
    assign valid_dram  = valid_dram_q;
    assign p0_ready    = p0_ready_q;
    assign p1_ready    = p1_ready_q;
    assign p0_dout     = p0_dout_q;
    assign p1_dout     = p1_dout_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: a round-robin and a fixed-priority instance share the
// requester stimulus, each with its own DRAM responder and transaction-level model.
module tb_dram_arbiter;
    localparam int TO = 16;

    logic sys_clk = 1'b0;
    logic rst = 1'b1;
    logic p0_valid = 1'b0, p0_rw = 1'b0;
    logic [26:0] p0_addr = '0;
    logic [31:0] p0_din = '0;
    logic p1_valid = 1'b0, p1_rw = 1'b0;
    logic [26:0] p1_addr = '0;
    logic [31:0] p1_din = '0;

    logic [1:0]       p0_ready, p1_ready, rw_dram, valid_dram, busy, err_timeout;
    logic [1:0][31:0] p0_dout, p1_dout, din_dram;
    logic [1:0][26:0] addr_dram;
    logic [1:0][31:0] dout_dram;
    logic [1:0]       ready_dram;

    always #5 sys_clk = ~sys_clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        dram_arbiter #(.ADDR_W(27), .DATA_W(32), .FIXED_PRIO(k), .TIMEOUT_CYCLES(TO)) u_dut (
            .sys_clk(sys_clk), .rst(rst),
            .p0_valid(p0_valid), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_din(p0_din),
            .p0_ready(p0_ready[k]), .p0_dout(p0_dout[k]),
            .p1_valid(p1_valid), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_din(p1_din),
            .p1_ready(p1_ready[k]), .p1_dout(p1_dout[k]),
            .addr_dram(addr_dram[k]), .din_dram(din_dram[k]), .rw_dram(rw_dram[k]),
            .valid_dram(valid_dram[k]), .dout_dram(dout_dram[k]), .ready_dram(ready_dram[k]),
            .busy(busy[k]), .err_timeout(err_timeout[k])
        );
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // DRAM responder: ready after resp_delay cycles of valid_dram (-1 = never)
    int resp_delay = 0;
    logic stray = 1'b0;
    int vcnt [2] = '{0, 0};
    int txn_cnt [2] = '{0, 0};
    logic [31:0] mem [logic [27:0]];

    always @(negedge sys_clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [27:0] key;
            key = {1'(k), addr_dram[k]};
            ready_dram[k] = 1'b0;
            if (stray) begin
                ready_dram[k] = 1'b1;
            end else if (valid_dram[k] === 1'b1) begin
                if (resp_delay >= 0 && vcnt[k] >= resp_delay) begin
                    ready_dram[k] = 1'b1;
                    txn_cnt[k]++;
                    if (rw_dram[k]) mem[key] = din_dram[k];
                    else dout_dram[k] = mem.exists(key) ? mem[key] : 32'h0;
                end
                vcnt[k]++;
            end else begin
                vcnt[k] = 0;
            end
        end
    end

    // Transaction-level model: outstanding flag, response flag, latched request
    logic        mdl_on = 1'b0;
    logic        m_pend [2], m_resp [2], m_rw [2], m_err [2];
    logic        m_rdy0 [2], m_rdy1 [2];
    int          m_gnt [2], m_last [2], m_wait [2];
    logic [26:0] m_addr [2];
    logic [31:0] m_din [2], m_dout0 [2], m_dout1 [2];

    always @(posedge sys_clk) begin
        int g;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pend[k] = 0; m_resp[k] = 0; m_rw[k] = 0; m_err[k] = 0;
                m_rdy0[k] = 0; m_rdy1[k] = 0; m_gnt[k] = 0; m_last[k] = 1; m_wait[k] = 0;
                m_addr[k] = 0; m_din[k] = 0; m_dout0[k] = 0; m_dout1[k] = 0;
            end else if (m_resp[k]) begin
                m_resp[k] = 0; m_rdy0[k] = 0; m_rdy1[k] = 0;
            end else if (m_pend[k]) begin
                if (ready_dram[k]) begin
                    m_pend[k] = 0;
                    m_resp[k] = 1;
                    if (m_gnt[k] == 0) begin
                        m_rdy0[k] = 1;
                        if (!m_rw[k]) m_dout0[k] = dout_dram[k];
                    end else begin
                        m_rdy1[k] = 1;
                        if (!m_rw[k]) m_dout1[k] = dout_dram[k];
                    end
                end else begin
                    if (m_wait[k] < TO) m_wait[k]++;
                    if (m_wait[k] >= TO) m_err[k] = 1;
                end
            end else if (p0_valid || p1_valid) begin
                if (p0_valid && p1_valid) g = (k == 1) ? 0 : 1 - m_last[k];
                else g = p0_valid ? 0 : 1;
                m_gnt[k] = g;
                m_last[k] = g;
                m_addr[k] = (g == 1) ? p1_addr : p0_addr;
                m_din[k] = (g == 1) ? p1_din : p0_din;
                m_rw[k] = (g == 1) ? p1_rw : p0_rw;
                m_pend[k] = 1;
                m_wait[k] = 0;
            end
        end
        if (rst) mdl_on = 1'b1;
    end

    always @(negedge sys_clk) begin
        if (mdl_on) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("valid_dram[%0d]", k), 64'(valid_dram[k]), 64'(m_pend[k]));
                check($sformatf("busy[%0d]", k), 64'(busy[k]), 64'(m_pend[k] | m_resp[k]));
                check($sformatf("p0_ready[%0d]", k), 64'(p0_ready[k]), 64'(m_rdy0[k]));
                check($sformatf("p1_ready[%0d]", k), 64'(p1_ready[k]), 64'(m_rdy1[k]));
                check($sformatf("p0_dout[%0d]", k), 64'(p0_dout[k]), 64'(m_dout0[k]));
                check($sformatf("p1_dout[%0d]", k), 64'(p1_dout[k]), 64'(m_dout1[k]));
                check($sformatf("err_timeout[%0d]", k), 64'(err_timeout[k]), 64'(m_err[k]));
                if (m_pend[k]) begin
                    check($sformatf("addr_dram[%0d]", k), 64'(addr_dram[k]), 64'(m_addr[k]));
                    check($sformatf("din_dram[%0d]", k), 64'(din_dram[k]), 64'(m_din[k]));
                    check($sformatf("rw_dram[%0d]", k), 64'(rw_dram[k]), 64'(m_rw[k]));
                end
            end
        end
    end

    // Grant history and pulse counts taken from the completion pulses
    int gq0 [$];
    int gq1 [$];
    int p0_pulses [2] = '{0, 0};
    int p1_pulses [2] = '{0, 0};

    always @(posedge sys_clk) begin
        if (p0_ready[0] === 1'b1) gq0.push_back(0);
        if (p1_ready[0] === 1'b1) gq0.push_back(1);
        if (p0_ready[1] === 1'b1) gq1.push_back(0);
        if (p1_ready[1] === 1'b1) gq1.push_back(1);
        for (int k = 0; k < 2; k++) begin
            if (p0_ready[k] === 1'b1) p0_pulses[k]++;
            if (p1_ready[k] === 1'b1) p1_pulses[k]++;
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    logic [26:0] cap_addr;
    logic [31:0] cap_din;
    logic        cap_rw;

    task automatic do_req(input int port, input logic rw, input logic [26:0] a,
                          input logic [31:0] d, output int lat);
        logic seen, cap;
        seen = 0; cap = 0; lat = 0;
        if (port == 0) begin p0_valid = 1; p0_rw = rw; p0_addr = a; p0_din = d; end
        else begin p1_valid = 1; p1_rw = rw; p1_addr = a; p1_din = d; end
        while (!seen && lat < 60) begin
            step();
            lat++;
            if (!cap && valid_dram[0] === 1'b1) begin
                cap = 1; cap_addr = addr_dram[0]; cap_din = din_dram[0]; cap_rw = rw_dram[0];
            end
            if ((port == 0 ? p0_ready[0] : p1_ready[0]) === 1'b1) seen = 1;
        end
        check("req_completed", 64'(seen), 64'(1));
        if (port == 0) p0_valid = 0; else p1_valid = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 2'b00 || valid_dram !== 2'b00) && n < 100) begin
            step();
            n++;
        end
        check("idle_reached", 64'(busy === 2'b00), 64'(1));
    endtask

    initial begin
        int lat, base0, base1, s0, s1, t0;
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            check("rst_valid_dram", 64'(valid_dram[k]), 64'(0));
            check("rst_busy", 64'(busy[k]), 64'(0));
            check("rst_err", 64'(err_timeout[k]), 64'(0));
            check("rst_addr_dram", 64'(addr_dram[k]), 64'(0));
            check("rst_p0_dout", 64'(p0_dout[k]), 64'(0));
            check("rst_p1_ready", 64'(p1_ready[k]), 64'(0));
        end
        rst = 0;

        // Port 0 write, completion 3 cycles after valid_dram
        resp_delay = 3;
        s0 = p0_pulses[0]; s1 = p1_pulses[0];
        do_req(0, 1'b1, 27'h2aaaaaa, 32'h33333333, lat);
        check("wr_addr", 64'(cap_addr), 64'h2aaaaaa);
        check("wr_din", 64'(cap_din), 64'h33333333);
        check("wr_rw", 64'(cap_rw), 64'(1));
        check("wr_latency", 64'(lat), 64'(5));
        wait_idle();
        step(); step();
        check("wr_p0_pulses", 64'(p0_pulses[0] - s0), 64'(1));
        check("wr_p1_pulses", 64'(p1_pulses[0] - s1), 64'(0));

        // Port 1 read-back of the same word
        do_req(1, 1'b0, 27'h2aaaaaa, 32'h0, lat);
        check("rd_p1_dout", 64'(p1_dout[0]), 64'h33333333);
        check("rd_p0_dout_kept", 64'(p0_dout[0]), 64'(0));
        wait_idle();

        // Both requesting continuously, immediate completion
        rst = 1; step(); rst = 0;
        resp_delay = 0;
        base0 = gq0.size(); base1 = gq1.size();
        p0_valid = 1; p0_rw = 0; p0_addr = 27'h10;
        p1_valid = 1; p1_rw = 0; p1_addr = 27'h20;
        repeat (12) step();
        p0_valid = 0; p1_valid = 0;
        wait_idle();
        check("rr_count", 64'(gq0.size() - base0 >= 4), 64'(1));
        check("fp_count", 64'(gq1.size() - base1 >= 4), 64'(1));
        if (gq0.size() - base0 >= 4 && gq1.size() - base1 >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rr_grant%0d", i), 64'(gq0[base0 + i]), 64'(i % 2));
                check($sformatf("fp_grant%0d", i), 64'(gq1[base1 + i]), 64'(0));
            end
        end

        // Minimum latency and back-to-back transactions
        t0 = txn_cnt[0];
        do_req(0, 1'b1, 27'h5, 32'hA5A5_0001, lat);
        check("min_latency", 64'(lat), 64'(2));
        do_req(1, 1'b1, 27'h6, 32'h5A5A_0002, lat);
        do_req(0, 1'b0, 27'h5, 32'h0, lat);
        check("b2b_p0_dout", 64'(p0_dout[0]), 64'hA5A5_0001);
        wait_idle();
        check("b2b_txn_count", 64'(txn_cnt[0] - t0), 64'(3));

        // Watchdog: no ready for 16 ISSUE cycles, then a late completion
        resp_delay = -1;
        p0_valid = 1; p0_rw = 0; p0_addr = 27'h2aaaaaa;
        lat = 0;
        while (valid_dram[0] !== 1'b1 && lat < 10) begin step(); lat++; end
        check("wd_issue_seen", 64'(valid_dram[0]), 64'(1));
        p0_valid = 0;
        repeat (TO - 1) step();
        check("wd_err_before", 64'(err_timeout[0]), 64'(0));
        step();
        check("wd_err_set", 64'(err_timeout[0]), 64'(1));
        check("wd_valid_held", 64'(valid_dram[0]), 64'(1));
        resp_delay = 0;
        lat = 0;
        while (p0_ready[0] !== 1'b1 && lat < 10) begin step(); lat++; end
        check("wd_late_ready", 64'(p0_ready[0]), 64'(1));
        check("wd_late_dout", 64'(p0_dout[0]), 64'h33333333);
        check("wd_err_sticky", 64'(err_timeout[0]), 64'(1));
        wait_idle();

        // Reset in the middle of ISSUE, then a stray ready
        resp_delay = -1;
        s1 = p1_pulses[0]; t0 = txn_cnt[0];
        p1_valid = 1; p1_rw = 1; p1_addr = 27'h7; p1_din = 32'hDEAD_BEEF;
        step(); step(); step();
        check("mid_valid_before", 64'(valid_dram[0]), 64'(1));
        rst = 1; p1_valid = 0;
        step();
        check("mid_valid_after", 64'(valid_dram[0]), 64'(0));
        check("mid_busy_after", 64'(busy[0]), 64'(0));
        rst = 0;
        stray = 1;
        step();
        stray = 0;
        repeat (4) step();
        check("mid_no_p1_ready", 64'(p1_pulses[0] - s1), 64'(0));
        check("mid_busy_stray", 64'(busy[0]), 64'(0));
        check("mid_no_txn", 64'(txn_cnt[0] - t0), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
